// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request/response handshake and feeds the IF/ID register.
// Optional halt-on-HLT support is built when FETCH_HALT_EN is defined.
module if_fetch_unit #(
   parameter int unsigned     PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [15:0]     NOP_INSTR = 16'hB000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_in,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   input  logic            imem_rdy,
   output logic [15:0]     instr_IF,
   output logic [PC_W-1:0] pc_IF,
   output logic            if_stall,
   output logic            if_flush,
   output logic            halted
);

   localparam int unsigned INSTR_W = 16;
   localparam logic [3:0]  HLT_OP  = 4'hF;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_HOLD   = 2'd1,
      S_DRAIN  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [PC_W-1:0]     target_q, target_d;
   logic [INSTR_W-1:0]  hold_q, hold_d;
   logic [PC_W-1:0]     pc_inc;
   logic                instr_valid;

   assign pc_inc = pc_q + PC_W'(1);

   // State register and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         target_q <= '0;
         hold_q   <= NOP_INSTR;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         hold_q   <= hold_d;
      end
   end

   // Next-state and output logic; a redirect always wins over stall and accept
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      target_d    = target_q;
      hold_d      = hold_q;
      instr_valid = 1'b0;
      imem_req    = 1'b0;
      imem_addr   = pc_q;
      instr_IF    = NOP_INSTR;
      pc_IF       = '0;
      if_stall    = 1'b0;
      if_flush    = 1'b1;
      halted      = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req    = 1'b1;
            instr_valid = imem_rdy;
            if (imem_rdy) begin
               instr_IF = imem_rdata;
            end
            if (redirect_valid) begin
               if (imem_rdy) begin
                  pc_d = redirect_pc;
               end else begin
                  target_d = redirect_pc;
                  state_d  = S_DRAIN;
               end
            end else if (imem_rdy && !stall_in) begin
               pc_d = pc_inc;
`ifdef FETCH_HALT_EN
               if (imem_rdata[15:12] == HLT_OP) begin
                  state_d = S_HALTED;
               end
`endif
            end else if (imem_rdy) begin
               hold_d  = imem_rdata;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            instr_valid = 1'b1;
            instr_IF    = hold_q;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end else if (!stall_in) begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
`ifdef FETCH_HALT_EN
               if (hold_q[15:12] == HLT_OP) begin
                  state_d = S_HALTED;
               end
`endif
            end
         end

         // Outstanding access must finish at the old address; its data is dropped
         S_DRAIN: begin
            imem_req = 1'b1;
            if (redirect_valid) begin
               target_d = redirect_pc;
            end
            if (imem_rdy) begin
               pc_d    = redirect_valid ? redirect_pc : target_q;
               state_d = S_FETCH;
            end
         end

`ifdef FETCH_HALT_EN
         S_HALTED: begin
            halted = 1'b1;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end
         end
`endif

         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (instr_valid) begin
         pc_IF = pc_inc;
      end
      if_stall = stall_in & ~redirect_valid;
      if_flush = redirect_valid | (~instr_valid & ~stall_in);

      // Quiet, flushing outputs for as long as reset is asserted
      if (rst) begin
         imem_req = 1'b0;
         instr_IF = NOP_INSTR;
         pc_IF    = '0;
         if_stall = 1'b0;
         if_flush = 1'b1;
         halted   = 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural imem with programmable latency and a scoreboard of instructions
// expected to enter IF/ID. Define FETCH_HALT_EN to exercise the halt feature.
module tb_if_fetch_unit;

   localparam int unsigned PC_W = 16;
   localparam logic [15:0] NOP  = 16'hB000;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            stall_in = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_pc = '0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            imem_rdy;
   logic [15:0]     instr_IF;
   logic [PC_W-1:0] pc_IF;
   logic            if_stall;
   logic            if_flush;
   logic            halted;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb_q[$];
   exp_t        mon_e;
   int          lat = 0;
   int          lat_cnt;
   logic        hold_off = 1'b0;
   logic        special_en = 1'b0;
   logic [15:0] special_addr = '0;
   logic [15:0] special_word = '0;

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .stall_in       (stall_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rdy       (imem_rdy),
      .instr_IF       (instr_IF),
      .pc_IF          (pc_IF),
      .if_stall       (if_stall),
      .if_flush       (if_flush),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {4'h1, a[11:0]};
   endfunction

   // imem model: response after `lat` wait cycles, or never while hold_off is set
   assign imem_rdata = (special_en && imem_addr == special_addr) ? special_word : mem_word(imem_addr);
   assign imem_rdy   = imem_req && !hold_off && (lat_cnt >= lat);

   always @(posedge clk or posedge rst) begin
      if (rst)                      lat_cnt <= 0;
      else if (!imem_req || imem_rdy) lat_cnt <= 0;
      else                          lat_cnt <= lat_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [15:0] instr, input logic [15:0] pc_if);
      exp_t e;
      e.instr = instr;
      e.pc    = pc_if;
      sb_q.push_back(e);
   endtask

   task automatic push_pc(input logic [15:0] pc);
      logic [15:0] nxt;
      nxt = pc + 16'd1;
      push_exp(mem_word(pc), nxt);
   endtask

   // An instruction enters IF/ID whenever neither stall nor flush is asserted
   always @(negedge clk) begin
      if (!rst && !if_flush && !if_stall) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_instr", 32'(instr_IF), 32'(mon_e.instr));
            chk("sb_pc", 32'(pc_IF), 32'(mon_e.pc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      // Reset: outputs quiet, stall masked
      stall_in = 1'b1;
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_instr", 32'(instr_IF), 32'(NOP));
      chk("rst_pc", 32'(pc_IF), 32'd0);
      chk("rst_flush", 32'(if_flush), 32'd1);
      chk("rst_stall", 32'(if_stall), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      step();
      stall_in = 1'b0;
      rst      = 1'b0;

      // 1: zero-latency back-to-back fetch
      for (int i = 0; i < 4; i++) push_pc(16'(i));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_addr", 32'(imem_addr), 32'(i));
         chk("t1_flush", 32'(if_flush), 32'd0);
         step();
      end

      // 2: two-cycle latency at pc=4
      lat = 2;
      push_pc(16'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_addr", 32'(imem_addr), 32'd4);
         chk("t2_flush", 32'(if_flush), (i < 2) ? 32'd1 : 32'd0);
         step();
      end
      lat = 0;

      // 3: stall while data is ready at pc=8
      for (int i = 5; i < 8; i++) push_pc(16'(i));
      repeat (3) step();
      stall_in = 1'b1;
      push_pc(16'd8);
      @(negedge clk);
      chk("t3_stall0", 32'(if_stall), 32'd1);
      step();
      @(negedge clk);
      chk("t3_req", 32'(imem_req), 32'd0);
      chk("t3_instr", 32'(instr_IF), 32'h1008);
      chk("t3_stall1", 32'(if_stall), 32'd1);
      step();
      stall_in = 1'b0;
      @(negedge clk);
      chk("t3_release_flush", 32'(if_flush), 32'd0);
      step();
      push_pc(16'd9);
      @(negedge clk);
      chk("t3_addr", 32'(imem_addr), 32'd9);
      step();

      // 4: redirect to 0x40 while an access to pc=3 is outstanding
      redirect_valid = 1'b1;
      redirect_pc    = 16'd3;
      @(negedge clk);
      chk("t4_flush_a", 32'(if_flush), 32'd1);
      step();
      hold_off    = 1'b1;
      redirect_pc = 16'h0040;
      @(negedge clk);
      chk("t4_addr_a", 32'(imem_addr), 32'd3);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_drain_req", 32'(imem_req), 32'd1);
      chk("t4_drain_addr", 32'(imem_addr), 32'd3);
      chk("t4_drain_pc", 32'(pc_IF), 32'd0);
      chk("t4_drain_flush", 32'(if_flush), 32'd1);
      step();
      hold_off = 1'b0;
      @(negedge clk);
      chk("t4_discard_instr", 32'(instr_IF), 32'(NOP));
      chk("t4_discard_flush", 32'(if_flush), 32'd1);
      step();
      push_pc(16'h0040);
      @(negedge clk);
      chk("t4_target_addr", 32'(imem_addr), 32'h40);
      step();

      // 4b: a second redirect during DRAIN replaces the target
      hold_off       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0020;
      step();
      redirect_pc = 16'h0030;
      step();
      redirect_valid = 1'b0;
      hold_off       = 1'b0;
      @(negedge clk);
      chk("t4b_old_addr", 32'(imem_addr), 32'h41);
      step();
      push_pc(16'h0030);
      @(negedge clk);
      chk("t4b_new_addr", 32'(imem_addr), 32'h30);
      step();

      // 5: redirect beats stall; pc wraps from 0xFFFF
      stall_in       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      @(negedge clk);
      chk("t5_flush", 32'(if_flush), 32'd1);
      chk("t5_stall", 32'(if_stall), 32'd0);
      step();
      stall_in       = 1'b0;
      redirect_valid = 1'b0;
      push_pc(16'hFFFF);
      @(negedge clk);
      chk("t5_addr_max", 32'(imem_addr), 32'hFFFF);
      step();
      push_pc(16'd0);
      @(negedge clk);
      chk("t5_addr_wrap", 32'(imem_addr), 32'd0);
      step();

      // 6: HLT opcode at pc=6
      special_en     = 1'b1;
      special_addr   = 16'd6;
      special_word   = 16'hF000;
      redirect_valid = 1'b1;
      redirect_pc    = 16'd6;
      step();
      redirect_valid = 1'b0;
      push_exp(16'hF000, 16'd7);
      @(negedge clk);
      chk("t6_addr", 32'(imem_addr), 32'd6);
      step();
`ifdef FETCH_HALT_EN
      @(negedge clk);
      chk("t6_halted", 32'(halted), 32'd1);
      chk("t6_req", 32'(imem_req), 32'd0);
      chk("t6_instr", 32'(instr_IF), 32'(NOP));
      chk("t6_flush", 32'(if_flush), 32'd1);
      step();
      stall_in = 1'b1;
      @(negedge clk);
      chk("t6_stall_flush", 32'(if_flush), 32'd0);
      chk("t6_stall", 32'(if_stall), 32'd1);
      chk("t6_still_halted", 32'(halted), 32'd1);
      step();
      stall_in       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'd2;
      @(negedge clk);
      chk("t6_redir_flush", 32'(if_flush), 32'd1);
      step();
      redirect_valid = 1'b0;
      push_pc(16'd2);
      @(negedge clk);
      chk("t6_resume_addr", 32'(imem_addr), 32'd2);
      chk("t6_resume_halted", 32'(halted), 32'd0);
      chk("t6_resume_req", 32'(imem_req), 32'd1);
      step();
`else
      push_pc(16'd7);
      @(negedge clk);
      chk("t6_halted", 32'(halted), 32'd0);
      chk("t6_req", 32'(imem_req), 32'd1);
      chk("t6_next_addr", 32'(imem_addr), 32'd7);
      step();
`endif

      // Reset in the middle of a fetch
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_req", 32'(imem_req), 32'd0);
      chk("rst2_flush", 32'(if_flush), 32'd1);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
